// File: rtl/fifo_pkg.sv
// Shared constants and bus helpers for the round-robin FIFO arbiter.
package fifo_pkg;

   localparam int unsigned FIFO_WIDTH_DEF = 8;
   localparam int unsigned NUM_REQ_DEF    = 4;
   localparam int unsigned WORD_W_DEF     = FIFO_WIDTH_DEF + 1;

   // Widest word and bus the slicing helper supports (payload up to 32 bits, 16 lanes).
   localparam int unsigned MAX_WORD_W = 33;
   localparam int unsigned MAX_BUS_W  = 16 * MAX_WORD_W;

   // Extract lane k's {valid, data} word from a zero-extended flattened bus.
   function automatic logic [MAX_WORD_W-1:0] lane_word(input logic [MAX_BUS_W-1:0] bus,
                                                       input int unsigned         k,
                                                       input int unsigned         word_w);
      logic [MAX_BUS_W-1:0]  sh;
      logic [MAX_WORD_W-1:0] mask;
      sh   = bus >> (k * word_w);
      mask = ~({MAX_WORD_W{1'b1}} << word_w);
      return sh[MAX_WORD_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Round-robin pick: first valid lane at or after ptr, modulo N.
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     valid_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic             found_o,
   output logic [PTR_W-1:0] idx_o
);

   logic [N-1:0]     rot;
   logic [PTR_W-1:0] pos;

   // Rotate so that lane ptr lands at position 0.
   always_comb begin
      rot = '0;
      for (int unsigned i = 0; i < N; i++) begin
         rot[i] = valid_i[(i + int'(ptr_i)) % N];
      end
   end

   // Priority-encode the lowest set bit of the rotated vector.
   always_comb begin
      found_o = 1'b0;
      pos     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found_o && rot[i]) begin
            found_o = 1'b1;
            pos     = PTR_W'(i);
         end
      end
   end

   // Un-rotate back to an absolute lane index.
   always_comb begin
      idx_o = PTR_W'((int'(pos) + int'(ptr_i)) % N);
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter feeding one registered, valid-tagged delay stage, with per-lane lock.
module fifo_rr_arbiter
   import fifo_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned NUM_REQ    = NUM_REQ_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ*(FIFO_WIDTH+1)-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]              lock_i,
   output logic [NUM_REQ-1:0]              ready_o,
   output logic [FIFO_WIDTH:0]             data_o,
   output logic [NUM_REQ-1:0]              grant_o,
   output logic [$clog2(NUM_REQ)-1:0]      owner_o,
   output logic                            locked_o
);

   localparam int unsigned WORD_W = FIFO_WIDTH + 1;
   localparam int unsigned PTR_W  = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] valid;
   logic               pick_found;
   logic [PTR_W-1:0]   pick_idx;
   logic               lock_hit;
   logic               win_valid;
   logic [PTR_W-1:0]   win_idx;
   logic [NUM_REQ-1:0] win_onehot;
   logic [WORD_W-1:0]  win_word;
   logic [MAX_BUS_W-1:0] bus_ext;

   logic [WORD_W-1:0]  data_q,   data_d;
   logic [NUM_REQ-1:0] grant_q,  grant_d;
   logic [PTR_W-1:0]   owner_q,  owner_d;
   logic               locked_q, locked_d;
   logic [PTR_W-1:0]   ptr_q,    ptr_d;

   // Lane valid flags are the MSB of each lane word.
   always_comb begin
      valid = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         valid[k] = req_data_i[k*WORD_W + FIFO_WIDTH];
      end
   end

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .valid_i (valid),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Winner selection: a held lock overrides round-robin only while the owner stays valid.
   always_comb begin
      lock_hit   = locked_q && valid[owner_q];
      win_valid  = lock_hit || pick_found;
      win_idx    = lock_hit ? owner_q : pick_idx;
      win_onehot = NUM_REQ'(1) << win_idx;
      bus_ext    = MAX_BUS_W'(req_data_i);
      win_word   = WORD_W'(lane_word(bus_ext, int'(win_idx), WORD_W));
   end

   // Next-state: register the winner, or emit a bubble and keep ptr/owner.
   always_comb begin
      data_d   = '0;
      grant_d  = '0;
      locked_d = 1'b0;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      if (win_valid) begin
         data_d   = win_word;
         grant_d  = win_onehot;
         locked_d = lock_i[win_idx];
         owner_d  = win_idx;
         ptr_d    = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q   <= '0;
         grant_q  <= '0;
         owner_q  <= '0;
         locked_q <= 1'b0;
         ptr_q    <= '0;
      end else begin
         data_q   <= data_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         locked_q <= locked_d;
         ptr_q    <= ptr_d;
      end
   end

   // Outputs: ready is suppressed during reset so nothing is accepted and lost.
   always_comb begin
      ready_o  = (win_valid && !rst) ? win_onehot : '0;
      data_o   = data_q;
      grant_o  = grant_q;
      owner_o  = owner_q;
      locked_o = locked_q;
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter (FIFO_WIDTH=8, NUM_REQ=4).
module tb_fifo_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [35:0] req_data_i;
   logic [3:0]  lock_i;
   logic [3:0]  ready_o;
   logic [8:0]  data_o;
   logic [3:0]  grant_o;
   logic [1:0]  owner_o;
   logic        locked_o;

   int checks   = 0;
   int failures = 0;

   fifo_rr_arbiter #(
      .FIFO_WIDTH (8),
      .NUM_REQ    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_data_i (req_data_i),
      .lock_i     (lock_i),
      .ready_o    (ready_o),
      .data_o     (data_o),
      .grant_o    (grant_o),
      .owner_o    (owner_o),
      .locked_o   (locked_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] bus4(input logic [8:0] w0, input logic [8:0] w1,
                                        input logic [8:0] w2, input logic [8:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req_data_i = '0;
      lock_i     = '0;
      step();
      rst = 1'b0;
   endtask

   logic [3:0] exp_g [5];
   logic [8:0] exp_d [5];

   initial begin
      // 1. Reset with all lanes valid
      rst        = 1'b1;
      lock_i     = '0;
      req_data_i = bus4(9'h100, 9'h101, 9'h102, 9'h103);
      #1;
      check("rst_ready",  32'(ready_o),  32'h0);
      check("rst_data",   32'(data_o),   32'h0);
      check("rst_grant",  32'(grant_o),  32'h0);
      check("rst_locked", 32'(locked_o), 32'h0);
      check("rst_owner",  32'(owner_o),  32'h0);
      step();
      check("rst_hold_ready", 32'(ready_o), 32'h0);
      check("rst_hold_data",  32'(data_o),  32'h0);
      rst        = 1'b0;
      req_data_i = '0;
      step();
      check("idle_data",  32'(data_o),  32'h0);
      check("idle_grant", 32'(grant_o), 32'h0);

      // 2. Single lane, then verify ptr moved to 3
      do_reset();
      req_data_i = bus4(9'h000, 9'h000, 9'h155, 9'h000);
      #1;
      check("single_ready", 32'(ready_o), 32'b0100);
      step();
      check("single_data",  32'(data_o),  32'h155);
      check("single_grant", 32'(grant_o), 32'b0100);
      req_data_i = '0;
      step();
      check("single_bubble", 32'(data_o),  32'h000);
      check("single_bub_g",  32'(grant_o), 32'h0);
      req_data_i = bus4(9'h100, 9'h000, 9'h000, 9'h103);
      #1;
      check("ptr3_ready", 32'(ready_o), 32'b1000);
      step();
      check("ptr3_data", 32'(data_o), 32'h103);

      // 3. Fairness and wrap, back-to-back
      do_reset();
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_d = '{9'h100, 9'h101, 9'h102, 9'h103, 9'h100};
      req_data_i = bus4(9'h100, 9'h101, 9'h102, 9'h103);
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("rr_ready%0d", i), 32'(ready_o), 32'(exp_g[i]));
         step();
         check($sformatf("rr_grant%0d", i), 32'(grant_o), 32'(exp_g[i]));
         check($sformatf("rr_data%0d", i),  32'(data_o),  32'(exp_d[i]));
      end

      // 4. Lock burst on lane0 while lane1 waits
      do_reset();
      req_data_i = bus4(9'h1A0, 9'h1B0, 9'h000, 9'h000);
      lock_i     = 4'b0001;
      #1;
      check("lk_ready0", 32'(ready_o), 32'b0001);
      step();
      check("lk_data0",   32'(data_o),   32'h1A0);
      check("lk_locked0", 32'(locked_o), 32'h1);
      check("lk_owner0",  32'(owner_o),  32'h0);
      req_data_i = bus4(9'h1A1, 9'h1B0, 9'h000, 9'h000);
      #1;
      check("lk_ready1", 32'(ready_o), 32'b0001);
      step();
      check("lk_data1",   32'(data_o),   32'h1A1);
      check("lk_locked1", 32'(locked_o), 32'h1);
      req_data_i = bus4(9'h1A2, 9'h1B0, 9'h000, 9'h000);
      lock_i     = 4'b0000;
      #1;
      check("lk_ready2", 32'(ready_o), 32'b0001);
      step();
      check("lk_data2",   32'(data_o),   32'h1A2);
      check("lk_locked2", 32'(locked_o), 32'h0);
      req_data_i = bus4(9'h000, 9'h1B0, 9'h000, 9'h000);
      #1;
      check("lk_ready3", 32'(ready_o), 32'b0010);
      step();
      check("lk_data3",  32'(data_o),  32'h1B0);
      check("lk_grant3", 32'(grant_o), 32'b0010);

      // 5. Lane3 holds under contention
      do_reset();
      req_data_i = bus4(9'h1C0, 9'h1C1, 9'h1C2, 9'h1C3);
      #1;
      check("hold_ready0", 32'(ready_o), 32'b0001);
      step();
      check("hold_data0", 32'(data_o), 32'h1C0);
      req_data_i = bus4(9'h000, 9'h1C1, 9'h1C2, 9'h1C3);
      #1;
      check("hold_ready1", 32'(ready_o), 32'b0010);
      step();
      check("hold_data1", 32'(data_o), 32'h1C1);
      req_data_i = bus4(9'h000, 9'h000, 9'h1C2, 9'h1C3);
      #1;
      check("hold_ready2", 32'(ready_o), 32'b0100);
      step();
      check("hold_data2", 32'(data_o), 32'h1C2);
      req_data_i = bus4(9'h000, 9'h000, 9'h000, 9'h1C3);
      #1;
      check("hold_ready3", 32'(ready_o), 32'b1000);
      step();
      check("hold_data3", 32'(data_o), 32'h1C3);
      req_data_i = '0;
      step();
      check("hold_after", 32'(data_o), 32'h000);

      // 6. Reset mid-stream while a lock is held
      do_reset();
      req_data_i = bus4(9'h1A0, 9'h1B0, 9'h000, 9'h000);
      lock_i     = 4'b0001;
      step();
      req_data_i = bus4(9'h1A1, 9'h1B0, 9'h000, 9'h000);
      step();
      check("mid_pre_data",   32'(data_o),   32'h1A1);
      check("mid_pre_locked", 32'(locked_o), 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_data",   32'(data_o),   32'h000);
      check("mid_rst_locked", 32'(locked_o), 32'h0);
      check("mid_rst_ready",  32'(ready_o),  32'h0);
      check("mid_rst_grant",  32'(grant_o),  32'h0);
      step();
      rst    = 1'b0;
      lock_i = 4'b0000;
      #1;
      check("mid_post_ready", 32'(ready_o), 32'b0001);
      step();
      check("mid_post_data", 32'(data_o), 32'h1A1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
